shift_register_n: RTL and testbench
===================================

Name: shift_register_n

Overview:
- Parametrised successor to the 8-bit load/reverse/nibble/shift register.
- Operand width is generalised to WIDTH bits; a 3-bit opcode is accepted per command.
- Shifts and rotates by a programmable amount run as a counted multi-cycle operation with start/busy/done handshake.
- Sits in the datapath as a general bit-manipulation register feeding ALU/output stages.

Parameters:
- WIDTH, 8, data width in bits; must be a multiple of 4 and >= 8
- AMT_W, $clog2(WIDTH), width of shift/rotate amount field

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only when busy=0
- op  in  3  opcode, sampled with start
- i  in  WIDTH  operand, sampled with start
- amt  in  AMT_W  shift/rotate amount, sampled with start
- ser_in  in  1  fill bit for shifts, sampled on every step cycle
- data  out  WIDTH  register contents
- busy  out  1  high while a multi-cycle op is stepping
- done  out  1  one-cycle pulse; data is final while done=1

Behaviour:
- Reset: rst=1 at an edge gives data=0, busy=0, done=0, internal count=0. rst has priority over everything. Reset mid-operation aborts with no done pulse.
- Opcodes:
  - 0 LOAD: data<=i
  - 1 REV: data<=i bit-reversed (data[k]=i[WIDTH-1-k])
  - 2 NIBREV: bits reversed within each 4-bit group (data[4g+k]=i[4g+3-k])
  - 3 SHL: data<={data[W-2:0],ser_in}
  - 4 SHR: data<={ser_in,data[W-1:1]}
  - 5 ROL: rotate left by one bit per step
  - 6 ROR: rotate right by one bit per step
  - 7 NOP: data unchanged
- Accept edge E0 occurs when start=1, busy=0 and rst=0.
  - Ops 0,1,2,7: data updated at E0; done=1 for the cycle after E0; busy stays 0.
  - Ops 3-6: data<=i at E0.
    - amt=0: done=1 after E0, busy stays 0.
    - Otherwise busy<=1 and count<=amt at E0. Each following edge applies one step and decrements count.
    - At the edge where count goes 1->0: busy<=0, done<=1.
    - Final data and done appear after edge E0+amt. Total latency is amt+1 edges.
- start while busy=1: ignored, with no queuing and no error. start in the done cycle is accepted normally (back-to-back commands allowed).
- done is deasserted on every edge that does not complete an operation.
- op, i and amt are captured at E0; later changes to them have no effect. ser_in is read live on each step edge.
- amt has no wrap beyond its field: the maximum is 2^AMT_W-1. For rotates, amt>=WIDTH simply keeps stepping.
- FSM states:
  - IDLE (busy=0): on accept of op 3-6 with amt!=0, go to STEP; else stay.
  - STEP (busy=1): return to IDLE when count reaches 0, or on rst.

Optional Feature:
- Macro SHREG_N_BARREL_EN.
- Defined: ops 3-6 complete in one cycle via a barrel shifter. data<=i shifted/rotated by amt at E0, and busy never asserts. Shift fill uses the ser_in value at E0 replicated into every vacated bit. done pulses the cycle after E0.
- Undefined: stepped behaviour as above; no barrel logic is synthesised.

Test Plan:
- Reset, then LOAD i=0xA5 -> data=0xA5 after E0, done=1 for exactly one cycle, busy=0 throughout.
- REV i=0x01 -> data=0x80; NIBREV i=0x12 -> data=0x84; NOP after that -> data stays 0x84, done pulses.
- ROL i=0x81 amt=3 -> data 0x81, 0x03, 0x06, 0x0C on successive edges; busy=1 for 3 cycles; done with data=0x0C. ROR i=0x81 amt=1 -> 0xC0.
- SHL i=0x0F amt=2, ser_in=1 -> 0x1F then 0x3F. Repeat with ser_in=0 -> 0x3C. SHR i=0xF0 amt=1, ser_in=1 -> 0xF8. amt=0 -> data=i, done the next cycle.
- ROL amt=5 with start re-pulsed (LOAD 0xFF) during busy -> ignored, rotate result unaffected. Issue a new start in the done cycle -> accepted.
- rst=1 after the 2nd step of ROL amt=5 -> data=0x00, busy=0, no done pulse. With SHREG_N_BARREL_EN, ROL i=0x81 amt=3 -> data=0x0C one edge after start, busy never 1.

Source files
------------

// File: rtl/shift_register_n.sv
// WIDTH-bit load/reverse/shift/rotate register with start/busy/done handshake.
// Define SHREG_N_BARREL_EN to complete shifts/rotates in one cycle.
module shift_register_n #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] i,
  input  logic [AMT_W-1:0] amt,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, STEP} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [AMT_W-1:0] count_q, count_n;
  logic [2:0]       op_q, op_n;
  logic             done_q, done_n;

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    for (int k = 0; k < WIDTH; k++)
      rev[k] = v[WIDTH-1-k];
  endfunction

  function automatic logic [WIDTH-1:0] nibrev(input logic [WIDTH-1:0] v);
    for (int g = 0; g < WIDTH/4; g++)
      for (int k = 0; k < 4; k++)
        nibrev[4*g+k] = v[4*g+3-k];
  endfunction

  function automatic logic [WIDTH-1:0] step(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] v,
    input logic             f
  );
    step = v;
    unique case (o)
      3'd3:    step = {v[WIDTH-2:0], f};
      3'd4:    step = {f, v[WIDTH-1:1]};
      3'd5:    step = {v[WIDTH-2:0], v[WIDTH-1]};
      3'd6:    step = {v[0], v[WIDTH-1:1]};
      default: step = v;
    endcase
  endfunction

`ifdef SHREG_N_BARREL_EN
  function automatic logic [WIDTH-1:0] barrel(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] v,
    input logic [AMT_W-1:0] n,
    input logic             f
  );
    logic [WIDTH-1:0]   ones;
    logic [2*WIDTH-1:0] dbl;
    int                 r;
    ones   = '1;
    r      = int'(n) % WIDTH;
    dbl    = '0;
    barrel = v;
    unique case (o)
      3'd3: barrel = (v << n) | (f ? ~(ones << n) : '0);
      3'd4: barrel = (v >> n) | (f ? ~(ones >> n) : '0);
      3'd5: begin
        dbl    = {v, v} << r;
        barrel = dbl[2*WIDTH-1:WIDTH];
      end
      3'd6: begin
        dbl    = {v, v} >> r;
        barrel = dbl[WIDTH-1:0];
      end
      default: barrel = v;
    endcase
  endfunction
`endif

  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    count_n = count_q;
    op_n    = op_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_n = op;
          unique case (op)
            3'd0: begin data_n = i;         done_n = 1'b1; end
            3'd1: begin data_n = rev(i);    done_n = 1'b1; end
            3'd2: begin data_n = nibrev(i); done_n = 1'b1; end
            3'd7: done_n = 1'b1;
            default: begin
`ifdef SHREG_N_BARREL_EN
              data_n = barrel(op, i, amt, ser_in);
              done_n = 1'b1;
`else
              data_n = i;
              if (amt == '0) begin
                done_n = 1'b1;
              end else begin
                count_n = amt;
                state_n = STEP;
              end
`endif
            end
          endcase
        end
      end
      STEP: begin
        data_n  = step(op_q, data_q, ser_in);
        count_n = count_q - 1'b1;
        // last step: leave STEP and publish the result
        if (count_q == AMT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      data_q  <= data_n;
      count_q <= count_n;
      op_q    <= op_n;
      done_q  <= done_n;
    end
  end

  assign data = data_q;
  assign busy = (state_q == STEP);
  assign done = done_q;

endmodule

// File: tb/tb_shift_register_n.sv
// Directed self-checking bench for shift_register_n (WIDTH=8).
// Honours SHREG_N_BARREL_EN for the single-cycle shift expectations.
module tb_shift_register_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] i;
  logic [2:0] amt;
  logic       ser_in;
  logic [7:0] data;
  logic       busy;
  logic       done;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  shift_register_n #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .i      (i),
    .amt    (amt),
    .ser_in (ser_in),
    .data   (data),
    .busy   (busy),
    .done   (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one-edge command strobe; operands scrambled afterwards
  task automatic cmd(input logic [2:0] o, input logic [7:0] v,
                     input logic [2:0] a, input logic f);
    start  = 1'b1;
    op     = o;
    i      = v;
    amt    = a;
    ser_in = f;
    tick();
    start = 1'b0;
    op    = 3'd0;
    i     = ~v;
    amt   = 3'd7;
  endtask

  task automatic finish(input string tag, input logic [7:0] exp);
    for (int k = 0; k < 40 && !done; k++) tick();
    chk({tag, "_done"}, 8'(done), 8'd1);
    chk({tag, "_data"}, data, exp);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; i = '0; amt = '0; ser_in = 1'b0;
    tick(); tick();
    chk("rst_data", data, 8'h00);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    rst = 1'b0;

    cmd(3'd0, 8'hA5, 3'd0, 1'b0);
    chk("load_data", data, 8'hA5);
    chk("load_done", 8'(done), 8'd1);
    chk("load_busy", 8'(busy), 8'd0);
    tick();
    chk("load_done_drop", 8'(done), 8'd0);
    chk("load_hold", data, 8'hA5);

    cmd(3'd1, 8'h01, 3'd0, 1'b0);
    chk("rev_data", data, 8'h80);
    chk("rev_done", 8'(done), 8'd1);
    cmd(3'd2, 8'h12, 3'd0, 1'b0);
    chk("nib_data", data, 8'h84);
    cmd(3'd7, 8'hFF, 3'd0, 1'b0);
    chk("nop_data", data, 8'h84);
    chk("nop_done", 8'(done), 8'd1);
    tick();

    cmd(3'd5, 8'h81, 3'd3, 1'b0);
`ifndef SHREG_N_BARREL_EN
    chk("rol3_e0", data, 8'h81);
    chk("rol3_busy0", 8'(busy), 8'd1);
    chk("rol3_nodone", 8'(done), 8'd0);
    tick();
    chk("rol3_s1", data, 8'h03);
    chk("rol3_busy1", 8'(busy), 8'd1);
    tick();
    chk("rol3_s2", data, 8'h06);
    chk("rol3_busy2", 8'(busy), 8'd1);
    tick();
`endif
    chk("rol3_final", data, 8'h0C);
    chk("rol3_done", 8'(done), 8'd1);
    chk("rol3_idle", 8'(busy), 8'd0);
    tick();
    chk("rol3_done_drop", 8'(done), 8'd0);

    cmd(3'd6, 8'h81, 3'd1, 1'b0);
    finish("ror1", 8'hC0);
    tick();

    cmd(3'd3, 8'h0F, 3'd2, 1'b1);
`ifndef SHREG_N_BARREL_EN
    tick();
    chk("shl1_s1", data, 8'h1F);
`endif
    finish("shl1", 8'h3F);
    tick();
    cmd(3'd3, 8'h0F, 3'd2, 1'b0);
    finish("shl0", 8'h3C);
    tick();
    cmd(3'd4, 8'hF0, 3'd1, 1'b1);
    finish("shr1", 8'hF8);
    tick();
    cmd(3'd5, 8'h5A, 3'd0, 1'b0);
    chk("amt0_data", data, 8'h5A);
    chk("amt0_done", 8'(done), 8'd1);
    chk("amt0_busy", 8'(busy), 8'd0);
    tick();

    cmd(3'd5, 8'h81, 3'd5, 1'b0);
`ifndef SHREG_N_BARREL_EN
    tick();
    start = 1'b1; op = 3'd0; i = 8'hFF;
    tick();
    start = 1'b0;
    chk("ign_step2", data, 8'h06);
    chk("ign_busy", 8'(busy), 8'd1);
`endif
    finish("rol5", 8'h30);
    cmd(3'd0, 8'h3C, 3'd0, 1'b0);
    chk("b2b_data", data, 8'h3C);
    chk("b2b_done", 8'(done), 8'd1);
    tick();

`ifndef SHREG_N_BARREL_EN
    cmd(3'd5, 8'h81, 3'd5, 1'b0);
    tick();
    tick();
    chk("abort_pre", data, 8'h06);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_data", data, 8'h00);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    tick();
    chk("abort_nodone", 8'(done), 8'd0);
    chk("abort_idle", 8'(busy), 8'd0);
`else
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_data", data, 8'h00);
    chk("rst2_done", 8'(done), 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
